psw_flag_stack: RTL
===================

Name: psw_flag_stack

Overview:
- Parametrised processor status word (PSW) register for the A5 datapath ALU, the successor to the fixed 4-flag JK PSW.
- Per-flag JK update from the ALU, a direct PSW load path, and a LIFO shadow stack for saving and restoring the PSW on interrupt or call entry and exit.
- Sits between the ALU flag logic and the control unit / branch logic.

Parameters:
- PSW_W, 16: total PSW width; bits [PSW_W-1:NFLAGS] are plain control bits.
- NFLAGS, 4: number of JK-updated flags in PSW[NFLAGS-1:0]; legal range 1..PSW_W; flag order is {N,Z,V,C} at bits [3:0].
- STACK_DEPTH, 4: number of shadow-stack entries; minimum 1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- FLAG_UPD  in  1  enables the JK update of the flags this cycle.
- FLAG_J  in  NFLAGS  per-flag J input.
- FLAG_K  in  NFLAGS  per-flag K input.
- WR_EN  in  1  direct load of the whole PSW.
- WR_DATA  in  PSW_W  data for the direct load.
- PUSH  in  1  save the current PSW to the stack.
- POP  in  1  restore the PSW from the stack top.
- ERR_CLR  in  1  clears STK_ERR.
- COND  in  4  condition code select (see Optional Feature).
- PSW  out  PSW_W  registered PSW.
- STK_CNT  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- STK_FULL  out  1  high when STK_CNT == STACK_DEPTH.
- STK_EMPTY  out  1  high when STK_CNT == 0.
- STK_ERR  out  1  sticky error flag: push when full, or pop when empty.
- COND_TRUE  out  1  condition evaluation result.

Behaviour:
- Reset (RST=1 at the edge):
  - PSW=0, STK_CNT=0, STK_ERR=0, so STK_EMPTY=1 and STK_FULL=0.
  - Stack contents are don't-care.
  - RST overrides every other input in that cycle, including mid-sequence push/pop traffic.
- Next-PSW priority, highest first:
  - POP with a non-empty stack: PSW <= top entry.
  - WR_EN: PSW <= WR_DATA.
  - FLAG_UPD: per flag i: J=0,K=0 hold; J=1,K=0 set; J=0,K=1 clear; J=1,K=1 toggle. Bits at and above NFLAGS hold.
  - Otherwise hold.
- PUSH alone, not full:
  - mem[STK_CNT] <= current PSW, i.e. the pre-edge value, before any same-cycle update; STK_CNT+1.
  - The same-cycle WR_EN/FLAG_UPD still applies to PSW.
- POP alone, not empty: PSW <= mem[STK_CNT-1]; STK_CNT-1. Same-cycle WR_EN/FLAG_UPD are ignored.
- PUSH and POP together, not empty (swap):
  - PSW <= top entry, and the top entry <= current PSW.
  - STK_CNT is unchanged.
- PUSH and POP together, empty: treated as a POP-when-empty error; the PUSH is also discarded.
- PUSH when full: the push is discarded; stack and STK_CNT are unchanged; STK_ERR <= 1. The PSW update still applies.
- POP when empty:
  - PSW is not loaded from the stack; the lower-priority WR_EN/FLAG_UPD path applies.
  - STK_ERR <= 1.
- STK_ERR:
  - Sticky; cleared by RST or by ERR_CLR.
  - A new error in the same cycle as ERR_CLR wins, leaving STK_ERR=1.
- Outputs:
  - All outputs are registered, except STK_FULL, STK_EMPTY and COND_TRUE, which are decoded from registers.
  - Latency from any input to PSW is 1 cycle.
- Stack depth has no wrap-around: STK_CNT saturates at 0 and STACK_DEPTH.

Optional Feature:
- Macro: PSW_COND_EVAL_EN.
- Defined (requires NFLAGS >= 4): COND_TRUE is decoded combinationally from the current registered PSW, with zero latency:
  - 0 AL=1, 1 EQ=Z, 2 NE=~Z, 3 CS=C, 4 CC=~C.
  - 5 MI=N, 6 PL=~N, 7 VS=V, 8 VC=~V.
  - 9 LT=N^V, 10 GE=~(N^V), 11 GT=~Z&~(N^V), 12 LE=Z|(N^V).
  - 13-15=0.
- Not defined: COND is ignored and COND_TRUE is tied to 0. Ports remain for interface stability.

Test Plan:
- RST=1 one cycle after random activity -> PSW=0x0000, STK_CNT=0, STK_EMPTY=1, STK_ERR=0.
- FLAG_UPD=1, J=4'b1010, K=4'b0110 from PSW=0x0003 -> PSW=0x0009 next cycle (N set, Z clear, V toggled 1->0, C held 1). With FLAG_UPD=0 the PSW is unchanged.
- Defaults: WR_EN 0x1230, then PUSH; then FLAG_UPD J=4'b1111 K=0; then POP -> PSW 0x1230 -> 0x123F -> 0x1230, with STK_CNT 1 then 0.
- Fill 4 pushes (STK_FULL=1), then a 5th PUSH -> STK_CNT stays 4 and STK_ERR=1. ERR_CLR -> STK_ERR=0. POP with STK_CNT=0 -> STK_ERR=1 and PSW unchanged.
- Stack top=0x00A0, PSW=0x0005, PUSH and POP together -> PSW=0x00A0, top=0x0005, STK_CNT unchanged.
- With PSW_COND_EVAL_EN: PSW=0x000A (N=1,V=1) -> COND=9 gives 0, COND=10 gives 1, COND=11 gives 1. PSW=0x0004 -> COND=1 gives 1, COND=12 gives 1. Without the macro, COND_TRUE=0 for all codes.

Source files
------------

// File: rtl/psw_flag_stack.sv
// psw_flag_stack: parametrised processor status word with per-flag JK update,
// direct load, and a LIFO shadow stack for PSW save/restore.
//
// Optional feature macro: PSW_COND_EVAL_EN. When defined, COND_TRUE decodes a
// branch condition from the registered flags {N,Z,V,C} = PSW[3:0]. This needs
// NFLAGS >= 4. When undefined, COND_TRUE is tied to 0.
//
// Ports:
//   CLK, RST             clock; synchronous active-high reset
//   FLAG_UPD/J/K         per-flag JK update of PSW[NFLAGS-1:0]
//   WR_EN/WR_DATA        direct load of the whole PSW
//   PUSH/POP             save/restore the PSW; both together swap with the top
//   ERR_CLR              clears the sticky STK_ERR
//   COND                 condition code select
//   PSW                  registered PSW
//   STK_CNT/FULL/EMPTY   stack occupancy
//   STK_ERR              sticky overflow/underflow flag
//   COND_TRUE            condition result

// JK cell for a single flag. J and K together toggle the flag.
module psw_jk_cell (
  input  logic j,
  input  logic k,
  input  logic q,
  output logic d
);
  assign d = (j & ~q) | (~k & q);
endmodule

module psw_flag_stack #(
  parameter  int PSW_W       = 16,
  parameter  int NFLAGS      = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLAG_UPD,
  input  logic [NFLAGS-1:0] FLAG_J,
  input  logic [NFLAGS-1:0] FLAG_K,
  input  logic              WR_EN,
  input  logic [PSW_W-1:0]  WR_DATA,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              ERR_CLR,
  input  logic [3:0]        COND,
  output logic [PSW_W-1:0]  PSW,
  output logic [CNT_W-1:0]  STK_CNT,
  output logic              STK_FULL,
  output logic              STK_EMPTY,
  output logic              STK_ERR,
  output logic              COND_TRUE
);

  logic [PSW_W-1:0] psw_q, psw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [PSW_W-1:0] mem_q [STACK_DEPTH];
  logic [PSW_W-1:0] mem_d [STACK_DEPTH];

  logic [NFLAGS-1:0] jk_flags;
  logic [PSW_W-1:0]  jk_psw;
  logic [PSW_W-1:0]  top;
  logic              empty, full;
  logic              pop_ok, push_ok, swap, err_new;
  logic [CNT_W-1:0]  wr_idx;
  logic              mem_we;

  for (genvar i = 0; i < NFLAGS; i++) begin : g_flag
    psw_jk_cell u_cell (
      .j (FLAG_J[i]),
      .k (FLAG_K[i]),
      .q (psw_q[i]),
      .d (jk_flags[i])
    );
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(STACK_DEPTH));

  // A pop on a non-empty stack always wins the PSW; with PUSH it becomes a swap.
  // PUSH+POP on an empty stack is an underflow and the push is dropped too.
  assign pop_ok  = POP & ~empty;
  assign swap    = pop_ok & PUSH;
  assign push_ok = PUSH & ~POP & ~full;
  assign err_new = (POP & empty) | (PUSH & ~POP & full);

  always_comb begin
    // Top-of-stack read as a compare-select so no index width mismatch arises.
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (CNT_W'(i) == cnt_q - CNT_W'(1)) top = mem_q[i];
  end

  always_comb begin
    jk_psw = psw_q;
    jk_psw[NFLAGS-1:0] = jk_flags;

    psw_d = psw_q;
    if (pop_ok)        psw_d = top;
    else if (WR_EN)    psw_d = WR_DATA;
    else if (FLAG_UPD) psw_d = jk_psw;

    cnt_d = cnt_q;
    if (push_ok)              cnt_d = cnt_q + CNT_W'(1);
    else if (pop_ok && !swap) cnt_d = cnt_q - CNT_W'(1);

    // A new error beats a same-cycle clear.
    err_d = err_q;
    if (err_new)      err_d = 1'b1;
    else if (ERR_CLR) err_d = 1'b0;

    // Stack writes always store the pre-edge PSW.
    mem_we = push_ok | swap;
    wr_idx = swap ? cnt_q - CNT_W'(1) : cnt_q;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (mem_we && CNT_W'(i) == wr_idx) mem_d[i] = psw_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      psw_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      psw_q <= psw_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset; only the count is cleared.
  always_ff @(posedge CLK) begin
    if (!RST) mem_q <= mem_d;
  end

`ifdef PSW_COND_EVAL_EN
  logic f_n, f_z, f_v, f_c;
  assign {f_n, f_z, f_v, f_c} = psw_q[3:0];

  always_comb begin
    COND_TRUE = 1'b0;
    case (COND)
      4'd0:    COND_TRUE = 1'b1;
      4'd1:    COND_TRUE = f_z;
      4'd2:    COND_TRUE = ~f_z;
      4'd3:    COND_TRUE = f_c;
      4'd4:    COND_TRUE = ~f_c;
      4'd5:    COND_TRUE = f_n;
      4'd6:    COND_TRUE = ~f_n;
      4'd7:    COND_TRUE = f_v;
      4'd8:    COND_TRUE = ~f_v;
      4'd9:    COND_TRUE = f_n ^ f_v;
      4'd10:   COND_TRUE = ~(f_n ^ f_v);
      4'd11:   COND_TRUE = ~f_z & ~(f_n ^ f_v);
      4'd12:   COND_TRUE = f_z | (f_n ^ f_v);
      default: COND_TRUE = 1'b0;
    endcase
  end
`else
  // COND stays on the port list for interface stability.
  logic unused_cond;
  assign unused_cond = ^COND;
  assign COND_TRUE   = 1'b0;
`endif

  assign PSW       = psw_q;
  assign STK_CNT   = cnt_q;
  assign STK_FULL  = full;
  assign STK_EMPTY = empty;
  assign STK_ERR   = err_q;

endmodule
